// File: rtl/iterative_alu_if.sv
// Request/response bundle between the operand-read stage and iterative_alu.
// The master drives operands and start; the slave (ALU) returns ready/done/result/zero.
interface iterative_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, alu_control, a, b,
    input  ready, done, result, zero
  );

  modport slave (
    input  start, alu_control, a, b,
    output ready, done, result, zero
  );
endinterface

// File: rtl/iterative_alu.sv
// Multi-cycle ALU with serial one-bit-per-cycle shifter and start/ready/done handshake.
// Define ALU_FAST_SHIFT_EN to compute shifts with a barrel shifter in a single pass.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready=1, waiting for start; non-shift ops resolve here
// S_SHIFT | serial shift, one bit per cycle, count down to zero
// S_DONE  | done=1 for one cycle, result/zero already registered
module iterative_alu #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  iterative_alu_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;

  logic [1:0]       state;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] work;
  logic [4:0]       count;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;

  logic [4:0]       shamt;
  logic             go_shift;
  logic [WIDTH-1:0] comb_result;
  logic [WIDTH-1:0] shift_step;

  always_comb begin
    shamt       = bus.b[4:0];
    comb_result = '0;
    case (bus.alu_control)
      OP_ADD: comb_result = bus.a + bus.b;
      OP_SUB: comb_result = bus.a - bus.b;
      OP_AND: comb_result = bus.a & bus.b;
      OP_OR:  comb_result = bus.a | bus.b;
      OP_XOR: comb_result = bus.a ^ bus.b;
      OP_SLT: comb_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: comb_result = bus.a << shamt;
      OP_SRL: comb_result = bus.a >> shamt;
      OP_SRA: comb_result = WIDTH'($signed(bus.a) >>> shamt);
`else
      // Only reached with a zero shift amount; nonzero amounts go serial.
      OP_SLL, OP_SRL, OP_SRA: comb_result = bus.a;
`endif
      default: comb_result = '0;
    endcase
  end

  always_comb begin
`ifdef ALU_FAST_SHIFT_EN
    go_shift = 1'b0;
`else
    go_shift = ((bus.alu_control == OP_SLL) || (bus.alu_control == OP_SRL) ||
                (bus.alu_control == OP_SRA)) && (shamt != 5'd0);
`endif
  end

  always_comb begin
    case (op_r)
      OP_SLL:  shift_step = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, work[WIDTH-1:1]};
      OP_SRA:  shift_step = {work[WIDTH-1], work[WIDTH-1:1]};
      default: shift_step = work;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_r     <= '0;
      work     <= '0;
      count    <= '0;
      result_r <= '0;
      zero_r   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_r  <= bus.alu_control;
            work  <= bus.a;
            count <= shamt;
            if (go_shift) begin
              state <= S_SHIFT;
            end else begin
              result_r <= comb_result;
              zero_r   <= (comb_result == '0);
              state    <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          work  <= shift_step;
          count <= count - 5'd1;
          if (count == 5'd1) begin
            result_r <= shift_step;
            zero_r   <= (shift_step == '0);
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready  = (state == S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_r;
  assign bus.zero   = zero_r;
endmodule

// File: tb/tb_iterative_alu.sv
// Directed-vector bench for iterative_alu: latency, result, zero, held start and reset abort.
module tb_iterative_alu;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  iterative_alu_if #(.WIDTH(32)) bus ();

  iterative_alu #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    return (k == 0) ? 1 : k + 1;
`endif
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({tag, "_ready_timeout"}, 32'(n), 32'd0);
  endtask

  // Issue one op, scramble inputs after accept, measure done latency and result.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int n;
    wait_ready(tag);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.alu_control = op;
    bus.a           = a;
    bus.b           = b;
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.alu_control = 4'b0000;
    bus.a           = 32'hDEAD_BEEF;
    bus.b           = 32'h1234_5677;
    @(negedge clk);
    n = 1;
    check({tag, "_ready_low"}, 32'(bus.ready), 32'd0);
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_zero"}, 32'(bus.zero), 32'(exp_res == 32'd0));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int n;
    int d1;
    bit got1;
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.alu_control = 4'b0000;
    bus.a           = 32'd0;
    bus.b           = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_zero", 32'(bus.zero), 32'd1);
    rst = 1'b0;

    do_op("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000);
    do_op("sub_zero", 4'b0001, 32'd5, 32'd5, 1, 32'h0000_0000);
    do_op("and", 4'b0010, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'h0F00_0F00);
    do_op("or", 4'b0011, 32'hF000_0000, 32'h0000_000F, 1, 32'hF000_000F);
    do_op("slt_neg", 4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0001);
    do_op("slt_pos", 4'b0101, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'h0000_0000);
    do_op("xor", 4'b0100, 32'hF0F0_F0F0, 32'hFFFF_0000, 1, 32'h0F0F_F0F0);
    do_op("sra4", 4'b1000, 32'h8000_0000, 32'h0000_0104, lat_of(4), 32'hF800_0000);
    do_op("srl4", 4'b0111, 32'h8000_0000, 32'h0000_0104, lat_of(4), 32'h0800_0000);
    do_op("sll31", 4'b0110, 32'h0000_0001, 32'h0000_001F, lat_of(31), 32'h8000_0000);
    do_op("sll0", 4'b0110, 32'h0000_1234, 32'h0000_0020, lat_of(0), 32'h0000_1234);
    do_op("illegal", 4'b1111, 32'h1234_5678, 32'h1111_1111, 1, 32'h0000_0000);

    // start held high through a shamt-8 SLL, then a second op waiting behind it
    wait_ready("held");
    @(negedge clk);
    bus.start       = 1'b1;
    bus.alu_control = 4'b0110;
    bus.a           = 32'h0000_0003;
    bus.b           = 32'h0000_0008;
    @(posedge clk);
    #1;
    bus.alu_control = 4'b0000;
    bus.a           = 32'd10;
    bus.b           = 32'd20;
    n    = 0;
    d1   = 0;
    got1 = 1'b0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) begin
        if (!got1) begin
          got1 = 1'b1;
          d1   = n;
          check("held_first_latency", 32'(n), 32'(lat_of(8)));
          check("held_first_result", bus.result, 32'h0000_0300);
        end else begin
          check("held_second_latency", 32'(n), 32'(lat_of(8) + 2));
          check("held_second_result", bus.result, 32'd30);
          break;
        end
      end
      if (bus.ready === 1'b1 && got1 && bus.start === 1'b1) begin
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
    end
    if (n >= 60) check("held_timeout", 32'(n), 32'(d1 + 2));
    bus.start = 1'b0;

    // reset pulse in the third shift cycle of a shamt-10 SRL
    wait_ready("rst_mid");
    @(negedge clk);
    bus.start       = 1'b1;
    bus.alu_control = 4'b0111;
    bus.a           = 32'hFFFF_FFFF;
    bus.b           = 32'h0000_000A;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_ready", 32'(bus.ready), 32'd1);
    check("rst_async_done", 32'(bus.done), 32'd0);
    check("rst_async_result", bus.result, 32'd0);
    check("rst_async_zero", 32'(bus.zero), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) n++;
    end
    check("rst_no_done", 32'(n), 32'd0);
    check("rst_result_held", bus.result, 32'd0);
    do_op("add_after_rst", 4'b0000, 32'd2, 32'd3, 1, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/iterative_alu.md
# iterative_alu

Multi-cycle ALU executing the 4-bit `alu_control` operation codes produced by the ALU decoder. It accepts operands and a code under a start/ready handshake, sequences shifts one bit per cycle through a small FSM, and returns a registered result with a one-cycle `done` pulse. It sits between the decoder/register-file read stage and writeback in the multi-cycle datapath variant.

## Interface
- `WIDTH`, 32, operand/result width; must be 32 (5-bit shift amount).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only while `ready`=1.
- `alu_control` input 4: operation code, latched on accept.
- `a` input WIDTH: operand A, latched on accept.
- `b` input WIDTH: operand B, latched on accept; `b[4:0]` = shift amount for shifts.
- `ready` output 1: FSM in IDLE; accepting.
- `done` output 1: one-cycle pulse; `result`/`zero` valid from this cycle on.
- `result` output WIDTH: registered result; holds until next `done`.
- `zero` output 1: registered, =1 iff `result`==0.

## Operation
- Codes: 0000 ADD a+b; 0001 SUB a−b; 0010 AND; 0011 OR; 0100 XOR; 0101 SLT (signed, result 1 or 0); 0110 SLL; 0111 SRL; 1000 SRA. All other codes: result 0, treated as single-cycle.
- ADD/SUB modulo 2^32, carry/overflow discarded. SLT compares two's-complement values. Shifts use `b[4:0]` only; `b[31:5]` ignored.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: `ready`=1. On `start`=1: latch `a`, `alu_control`, `count`←`b[4:0]`. Shift code with `count`≠0 → SHIFT; otherwise compute result → DONE.
  - SHIFT: each cycle shift working register one bit (SLL fills 0 at LSB; SRL fills 0 at MSB; SRA replicates bit 31), `count`−1; after the step where `count` reaches 0 → DONE.
  - DONE: `done`=1 for exactly this cycle, `result`/`zero` updated; next cycle IDLE.
- `start` while `ready`=0: ignored, no queuing.
- Reset values: state IDLE, `ready`=1, `done`=0, `result`=0, `zero`=1, `count`=0.
- `rst` asserted mid-operation: immediately to IDLE, no `done`, `result` cleared to 0, operation discarded.

## Timing
- Accept edge E (`start`=1 & `ready`=1). `ready` falls in the cycle after E.
- Non-shift or shift with shamt 0: `done`=1 in cycle E+1, `ready`=1 in cycle E+2.
- Shift with shamt k (1..31): k SHIFT cycles; `done`=1 in cycle E+1+k; `ready`=1 in cycle E+2+k.
- Back-to-back throughput: one op per 2 cycles (non-shift), per k+2 cycles (shift).
- `result` changes only in the DONE cycle or on reset; stable otherwise.
- Inputs `a`, `b`, `alu_control` may change freely after E.

## Configuration
- `ALU_FAST_SHIFT_EN` defined: shifts computed combinationally (barrel) at accept; every code, including shifts of any amount, finishes with `done` in E+1; SHIFT state unused and never entered.
- Undefined (default): serial shifting as above, latency shamt-dependent.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `ready`=1, `done`=0, `result`=0, `zero`=1 without a clock edge.
- ADD a=0x7FFFFFFF b=1 → `done` at E+1, result 0x80000000, zero=0; SUB a=5 b=5 → result 0, zero=1.
- SLT a=0xFFFFFFFF b=1 → result 1; a=1 b=0xFFFFFFFF → result 0; XOR 0xF0F0F0F0^0xFFFF0000 → 0x0F0FF0F0.
- SRA a=0x80000000 b=0x00000104 (shamt 4) → `done` at E+5 (E+1 with `ALU_FAST_SHIFT_EN`), result 0xF8000000; SRL same → 0x08000000; SLL a=1 shamt 31 → 0x80000000 at E+32.
- `start` held high during a shamt-8 SLL with different operands → second op accepted only at the edge where `ready`=1 (E+10); first result unaffected; illegal code 1111 → result 0, `done` at E+1.
- `rst` pulse in SHIFT cycle 3 of a shamt-10 shift → no `done`, `ready`=1, result 0; subsequent ADD 2+3 → 5 at E+1.
